// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and defaults for the dual-port RAM arbiter
// Purpose: address/data width defaults, requester-index width, owner record
//          and the round-robin increment helper used by mem_port_arbiter.
// Ports:   none (package).
package mem_arb_pkg;

  localparam int AW_DEF = 4;
  localparam int DW_DEF = 16;
  // Wide enough for NREQ up to 8.
  localparam int IDX_W  = 3;

  typedef struct packed {
    logic             vld;
    logic [IDX_W-1:0] idx;
  } owner_t;

  // Index following i in a ring of n requesters.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i, input int n);
    if (int'(i) == n - 1) return '0;
    return i + 1'b1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// rtl/mem_port_arbiter_rr_pick2.sv - combinational first/second round-robin pick
// Purpose: scans valid_i starting at ptr_i (wrapping) and reports the first
//          and second set bits found.
// Ports:   valid_i  request vector
//          ptr_i    scan start index
//          a_found_o/a_idx_o  first winner
//          b_found_o/b_idx_o  second winner
module rr_pick2
  import mem_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = IDX_W
) (
  input  logic [NREQ-1:0] valid_i,
  input  logic [IW-1:0]   ptr_i,
  output logic            a_found_o,
  output logic [IW-1:0]   a_idx_o,
  output logic            b_found_o,
  output logic [IW-1:0]   b_idx_o
);

  // One extra bit so ptr + offset cannot overflow before the wrap.
  logic [IW:0] pos;

  always_comb begin
    a_found_o = 1'b0;
    a_idx_o   = '0;
    b_found_o = 1'b0;
    b_idx_o   = '0;
    pos       = '0;
    for (int k = 0; k < NREQ; k++) begin
      pos = {1'b0, ptr_i} + (IW+1)'(k);
      if (pos >= (IW+1)'(NREQ)) pos = pos - (IW+1)'(NREQ);
      for (int j = 0; j < NREQ; j++) begin
        if (pos == (IW+1)'(j) && valid_i[j]) begin
          if (!a_found_o) begin
            a_found_o = 1'b1;
            a_idx_o   = IW'(j);
          end else if (!b_found_o) begin
            b_found_o = 1'b1;
            b_idx_o   = IW'(j);
          end
        end
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter sharing a dual-port RAM between NREQ requesters
// Purpose: grants up to two requests per cycle (winner A -> port 1, winner B
//          -> port 2), blocks B on a same-address hazard involving a write,
//          and returns a one-cycle-latency response to each granted requester.
// Ports:   clk, rst (async, active high)
//          req_valid/req_we/req_addr/req_wdata  requester side inputs
//          req_ready                            combinational grant
//          rsp_valid/rsp_rdata                  response, one cycle after grant
//          mem_addr1/2, mem_din1/2, mem_we1/2   RAM port drive
//          mem_dout1/2                          registered RAM read data
//          conflict_cnt                         saturating deferred-grant count
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int AW   = AW_DEF,
  parameter int DW   = DW_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ-1:0]    req_we,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]    req_ready,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [NREQ*DW-1:0] rsp_rdata,
  output logic [AW-1:0]      mem_addr1,
  output logic [AW-1:0]      mem_addr2,
  output logic [DW-1:0]      mem_din1,
  output logic [DW-1:0]      mem_din2,
  output logic               mem_we1,
  output logic               mem_we2,
  input  logic [DW-1:0]      mem_dout1,
  input  logic [DW-1:0]      mem_dout2,
  output logic [15:0]        conflict_cnt
);

  localparam int IW = IDX_W;

  logic [IW-1:0] ptr_q, ptr_d;
  owner_t        own1_q, own1_d, own2_q, own2_d;
  logic [15:0]   cnt_q, cnt_d;

  logic          a_found, b_found;
  logic [IW-1:0] a_idx, b_idx;

  logic [AW-1:0] addr_a, addr_b;
  logic [DW-1:0] wdata_a, wdata_b;
  logic          we_a, we_b;
  logic          hazard, grant_a, grant_b;

  rr_pick2 #(.NREQ(NREQ), .IW(IW)) u_pick (
    .valid_i   (req_valid),
    .ptr_i     (ptr_q),
    .a_found_o (a_found),
    .a_idx_o   (a_idx),
    .b_found_o (b_found),
    .b_idx_o   (b_idx)
  );

  // Winner request fields, selected with constant indices so the mux stays flat.
  always_comb begin
    addr_a  = '0;
    addr_b  = '0;
    wdata_a = '0;
    wdata_b = '0;
    we_a    = 1'b0;
    we_b    = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (a_idx == IW'(i)) begin
        addr_a  = req_addr[i*AW +: AW];
        wdata_a = req_wdata[i*DW +: DW];
        we_a    = req_we[i];
      end
      if (b_idx == IW'(i)) begin
        addr_b  = req_addr[i*AW +: AW];
        wdata_b = req_wdata[i*DW +: DW];
        we_b    = req_we[i];
      end
    end
  end

  // Grant, port drive and next-state logic. rst gates the grants directly so
  // the RAM ports go idle the moment reset rises.
  always_comb begin
    hazard  = a_found && b_found && (addr_a == addr_b) && (we_a || we_b);
    grant_a = a_found && !rst;
    grant_b = b_found && !hazard && !rst;

    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_a && a_idx == IW'(i)) req_ready[i] = 1'b1;
      if (grant_b && b_idx == IW'(i)) req_ready[i] = 1'b1;
    end

    mem_addr1 = grant_a ? addr_a  : '0;
    mem_din1  = grant_a ? wdata_a : '0;
    mem_we1   = grant_a && we_a;
    mem_addr2 = grant_b ? addr_b  : '0;
    mem_din2  = grant_b ? wdata_b : '0;
    mem_we2   = grant_b && we_b;

    // B is always later in scan order than A, so it is the last granted.
    ptr_d = ptr_q;
    if (grant_b)      ptr_d = next_idx(b_idx, NREQ);
    else if (grant_a) ptr_d = next_idx(a_idx, NREQ);

    own1_d.vld = grant_a;
    own1_d.idx = grant_a ? a_idx : '0;
    own2_d.vld = grant_b;
    own2_d.idx = grant_b ? b_idx : '0;

    cnt_d = cnt_q;
    if (hazard && !rst && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q  <= '0;
      own1_q <= '0;
      own2_q <= '0;
      cnt_q  <= '0;
    end else begin
      ptr_q  <= ptr_d;
      own1_q <= own1_d;
      own2_q <= own2_d;
      cnt_q  <= cnt_d;
    end
  end

  // The two owners are always distinct requesters, so the ORed slices never overlap.
  always_comb begin
    rsp_valid = '0;
    rsp_rdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (own1_q.vld && own1_q.idx == IW'(i)) begin
        rsp_valid[i]          = 1'b1;
        rsp_rdata[i*DW +: DW] = mem_dout1;
      end
      if (own2_q.vld && own2_q.idx == IW'(i)) begin
        rsp_valid[i]          = 1'b1;
        rsp_rdata[i*DW +: DW] = mem_dout2;
      end
    end
  end

  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid, req_we, req_ready, rsp_valid;
  logic [15:0] req_addr;
  logic [63:0] req_wdata, rsp_rdata;
  logic [3:0]  mem_addr1, mem_addr2;
  logic [15:0] mem_din1, mem_din2, mem_dout1, mem_dout2, conflict_cnt;
  logic        mem_we1, mem_we2;

  int checks = 0;
  int errors = 0;
  int rsp_cnt [4];

  typedef struct {
    int          idx;
    logic [15:0] data;
  } exp_t;
  exp_t        sb[$];
  logic [15:0] exp_mem [16];
  logic [15:0] ram     [16];

  always #5 clk = ~clk;

  mem_port_arbiter #(.NREQ(4), .AW(4), .DW(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .mem_addr1(mem_addr1), .mem_addr2(mem_addr2), .mem_din1(mem_din1), .mem_din2(mem_din2),
    .mem_we1(mem_we1), .mem_we2(mem_we2), .mem_dout1(mem_dout1), .mem_dout2(mem_dout2),
    .conflict_cnt(conflict_cnt)
  );

  // Dual-port synchronous RAM: registered read returning pre-write contents.
  always @(posedge clk) begin
    mem_dout1 <= ram[mem_addr1];
    mem_dout2 <= ram[mem_addr2];
    if (mem_we1) ram[mem_addr1] <= mem_din1;
    if (mem_we2) ram[mem_addr2] <= mem_din2;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One arbitration cycle: drive, check grant/ports at negedge, push expected
  // responses, then after the edge pop and compare the responses.
  task automatic cyc(input string tag, input logic [3:0] v, input logic [3:0] we,
                     input logic [15:0] addr, input logic [63:0] wd,
                     input logic [3:0] exp_rdy, input logic [3:0] exp_a1,
                     input logic [3:0] exp_a2, input logic [1:0] exp_we);
    exp_t        e;
    logic [3:0]  exp_v;
    logic [63:0] exp_d;
    logic [3:0]  a;
    req_valid = v;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    @(negedge clk);
    chk({tag, "/req_ready"}, 64'(req_ready), 64'(exp_rdy));
    chk({tag, "/mem_addr1"}, 64'(mem_addr1), 64'(exp_a1));
    chk({tag, "/mem_addr2"}, 64'(mem_addr2), 64'(exp_a2));
    chk({tag, "/mem_we"},    64'({mem_we2, mem_we1}), 64'(exp_we));
    for (int i = 0; i < 4; i++) begin
      if (exp_rdy[i]) begin
        a      = addr[i*4 +: 4];
        e.idx  = i;
        e.data = exp_mem[a];
        sb.push_back(e);
        if (we[i]) exp_mem[a] = wd[i*16 +: 16];
      end
    end
    @(posedge clk);
    #1;
    exp_v = '0;
    exp_d = '0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      exp_v[e.idx] = 1'b1;
      exp_d[e.idx*16 +: 16] = e.data;
    end
    chk({tag, "/rsp_valid"}, 64'(rsp_valid), 64'(exp_v));
    chk({tag, "/rsp_rdata"}, rsp_rdata, exp_d);
    for (int i = 0; i < 4; i++) rsp_cnt[i] += int'(rsp_valid[i]);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      ram[i]     <= 16'h0;
      exp_mem[i]  = 16'h0;
    end
    ram[3]     <= 16'h1234;
    ram[2]     <= 16'h0042;
    exp_mem[3]  = 16'h1234;
    exp_mem[2]  = 16'h0042;
    for (int i = 0; i < 4; i++) rsp_cnt[i] = 0;

    // Reset: grants and ports must be idle even with all requests present.
    rst       = 1'b1;
    req_valid = 4'b1111;
    req_we    = 4'b1111;
    req_addr  = 16'h1234;
    req_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
    #2;
    chk("rst/req_ready",    64'(req_ready), 64'h0);
    chk("rst/mem_we",       64'({mem_we2, mem_we1}), 64'h0);
    chk("rst/mem_addr1",    64'(mem_addr1), 64'h0);
    chk("rst/mem_din1",     64'(mem_din1), 64'h0);
    chk("rst/rsp_valid",    64'(rsp_valid), 64'h0);
    chk("rst/rsp_rdata",    rsp_rdata, 64'h0);
    chk("rst/conflict_cnt", 64'(conflict_cnt), 64'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // ptr 0 -> 1
    cyc("rd0", 4'b0001, 4'b0000, 16'h0003, 64'h0, 4'b0001, 4'h3, 4'h0, 2'b00);
    // ptr 1: two reads of one address both granted; ptr -> 3
    cyc("rdrd", 4'b0110, 4'b0000, 16'h0330, 64'h0, 4'b0110, 4'h3, 4'h3, 2'b00);
    chk("rdrd/conflict_cnt", 64'(conflict_cnt), 64'h0);
    // ptr 3 -> 0
    cyc("rd3", 4'b1000, 4'b0000, 16'h0000, 64'h0, 4'b1000, 4'h0, 4'h0, 2'b00);
    // ptr 0: two writes, ptr -> 3
    cyc("wr02", 4'b0101, 4'b0101, 16'h0905, 64'h0000_5555_0000_AAAA, 4'b0101, 4'h5, 4'h9, 2'b11);
    // ptr 3: requester 3 wins port 1; writes read back; ptr -> 1
    cyc("rd30", 4'b1001, 4'b0000, 16'h9005, 64'h0, 4'b1001, 4'h9, 4'h5, 2'b00);
    // ptr 1: write/read hazard on addr 7, only requester 1 granted; ptr -> 2
    cyc("haz", 4'b0110, 4'b0010, 16'h0770, 64'h0000_0000_7777_0000, 4'b0010, 4'h7, 4'h0, 2'b01);
    chk("haz/conflict_cnt", 64'(conflict_cnt), 64'h1);
    // deferred read sees the new value; ptr -> 3
    cyc("haz2", 4'b0100, 4'b0000, 16'h0700, 64'h0, 4'b0100, 4'h7, 4'h0, 2'b00);
    chk("haz2/conflict_cnt", 64'(conflict_cnt), 64'h1);
    // ptr 3 -> 0
    cyc("rd3b", 4'b1000, 4'b0000, 16'h0000, 64'h0, 4'b1000, 4'h0, 4'h0, 2'b00);

    // Round robin with all four holding reads.
    for (int i = 0; i < 4; i++) rsp_cnt[i] = 0;
    cyc("rr0", 4'b1111, 4'b0000, 16'hDCBA, 64'h0, 4'b0011, 4'hA, 4'hB, 2'b00);
    cyc("rr1", 4'b1111, 4'b0000, 16'hDCBA, 64'h0, 4'b1100, 4'hC, 4'hD, 2'b00);
    cyc("rr2", 4'b1111, 4'b0000, 16'hDCBA, 64'h0, 4'b0011, 4'hA, 4'hB, 2'b00);
    cyc("rr3", 4'b1111, 4'b0000, 16'hDCBA, 64'h0, 4'b1100, 4'hC, 4'hD, 2'b00);
    for (int i = 0; i < 4; i++) chk($sformatf("rr/rsp_cnt%0d", i), 64'(rsp_cnt[i]), 64'd2);

    // ptr 0: swap write returns 0042; ptr -> 1, then read back BEEF; ptr -> 2
    cyc("swap", 4'b0001, 4'b0001, 16'h0002, 64'h0000_0000_0000_BEEF, 4'b0001, 4'h2, 4'h0, 2'b01);
    cyc("swaprd", 4'b0010, 4'b0000, 16'h0020, 64'h0, 4'b0010, 4'h2, 4'h0, 2'b00);

    // Reset in the cycle after a grant: the response must vanish at once.
    req_valid = 4'b0001;
    req_we    = 4'b0000;
    req_addr  = 16'h0003;
    req_wdata = 64'h0;
    @(negedge clk);
    chk("mrst/req_ready", 64'(req_ready), 64'h1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("mrst/rsp_valid",    64'(rsp_valid), 64'h0);
    chk("mrst/rsp_rdata",    rsp_rdata, 64'h0);
    chk("mrst/req_ready_rst", 64'(req_ready), 64'h0);
    chk("mrst/mem_addr1",    64'(mem_addr1), 64'h0);
    chk("mrst/conflict_cnt", 64'(conflict_cnt), 64'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc("post_idle", 4'b0000, 4'b0000, 16'h0000, 64'h0, 4'b0000, 4'h0, 4'h0, 2'b00);
    // ptr back at 0 -> requesters 0 and 1 win
    cyc("post_rr", 4'b1111, 4'b0000, 16'h3333, 64'h0, 4'b0011, 4'h3, 4'h3, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the two ports of the team's 16x16 dual-port synchronous RAM between NREQ independent requesters. Each cycle it grants up to two requests in round-robin order, one per RAM port, and drives the RAM port signals. It suppresses same-address hazards between the two ports and returns a tagged one-cycle-latency response to each granted requester. It sits between the requester-side logic and the RAM instance; the RAM itself stays outside this block.

## Interface
- NREQ, 4: number of requesters, 2..8.
- AW, 4: address width; must match the RAM.
- DW, 16: data width; must match the RAM.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  request present, one bit per requester.
- req_we  in  NREQ  1 = write, 0 = read.
- req_addr  in  NREQ*AW  per-requester address; requester i uses slice [i*AW +: AW].
- req_wdata  in  NREQ*DW  per-requester write data; requester i uses slice [i*DW +: DW].
- req_ready  out  NREQ  grant; combinational.
- rsp_valid  out  NREQ  response strobe, registered.
- rsp_rdata  out  NREQ*DW  response data; requester i uses slice [i*DW +: DW].
- mem_addr1, mem_addr2  out  AW  RAM port addresses.
- mem_din1, mem_din2  out  DW  RAM port write data.
- mem_we1, mem_we2  out  1  RAM port write enables.
- mem_dout1, mem_dout2  in  DW  registered RAM read data; holds pre-write contents.
- conflict_cnt  out  16  saturating count of deferred grants.

## Operation
- A transfer occurs when req_valid[i] & req_ready[i].
- Once req_valid[i] is asserted, the requester holds it and keeps we/addr/wdata stable until the transfer.
- Round-robin pointer ptr (0..NREQ-1). Scan order: ptr, ptr+1, …, wrapping modulo NREQ.
  - First valid requester found is winner A, mapped to port 1.
  - Next valid requester found is winner B, mapped to port 2.
- Hazard rule: B is not granted if addr(A) == addr(B) and either request is a write. B stays pending and conflict_cnt increments (saturates at 16'hFFFF). Two reads to the same address are both granted.
- Port driving:
  - Granted port: addr, din and we taken from its winner.
  - Idle port: addr = 0, din = 0, we = 0.
- Pointer update on any grant: ptr <= (index of last granted requester + 1) mod NREQ. With no grant, ptr holds.
- Owner pipeline: per port, register owner_vld and owner_idx at the grant edge.
- Response, one cycle after grant:
  - rsp_valid[owner] = 1.
  - rsp_rdata[owner] = the matching mem_doutN.
- Every transaction gets a response, writes included. For a write, rsp_rdata is the pre-write contents of the address (swap semantics).
- rsp_rdata slices are 0 whenever the corresponding rsp_valid bit is 0.
- A requester may be granted again in the cycle its previous response appears.
- Fairness: any held request is granted within NREQ cycles.

## Timing
- Reset values: ptr = 0, owner_vld = 0, owner_idx = 0, conflict_cnt = 0, rsp_valid = 0, rsp_rdata = 0. The mem_* outputs show the idle values and req_ready = 0 while rst is high.
- Reset asserted mid-operation: any in-flight response is dropped with no rsp_valid. RAM contents are not cleared.
- Latency:
  - Grant is in cycle t (combinational from inputs).
  - The RAM samples at the t edge.
  - rsp_valid/rsp_rdata are valid during cycle t+1.
- Throughput: up to 2 transactions per cycle.
- Critical path: req_valid → scan → hazard compare → mem_addr/we. No registers are allowed in that path.

## Structure
- Shared package mem_arb_pkg holds the AW/DW defaults and the owner-record typedef (vld, idx).
- One sub-module, rr_pick2: given a valid vector and ptr, it returns the first and second winner indices with their found flags. It is purely combinational.
- The top level holds the hazard compare, ptr register, owner pipeline, response mux and conflict counter.

## Test plan
- Single read after reset, requester 0, addr 3, RAM[3] = 16'h1234 → req_ready[0] in cycle 0; rsp_valid = 4'b0001 and rsp_rdata[0] = 16'h1234 in cycle 1.
- Requesters 0 and 2 write addr 5 and addr 9 simultaneously, ptr = 0 → both granted; port 1 carries addr 5 and port 2 carries addr 9; both writes land; ptr becomes 3.
- Requester 1 writes addr 7, requester 2 reads addr 7, ptr = 1 → only requester 1 is granted; requester 2 is granted next cycle and reads the new value; conflict_cnt = 1.
- All four requesters hold valid reads for 4 cycles → grant pairs are (0,1), (2,3), (0,1), (2,3); each requester gets exactly 2 responses.
- Write 16'hBEEF to addr 2, which holds 16'h0042 → the write response returns 16'h0042; a later read returns 16'hBEEF.
- Assert rst in the cycle after a grant → no rsp_valid appears; all outputs return to their reset values immediately, without waiting for a clock edge.
